// File: rtl/oam_dma_ctrl.sv
// Sprite DMA controller: a write to $4014 stalls the CPU and copies one 256-byte
// page to the PPU OAM data port ($2004) using get/put M2 cycle alternation.
module oam_dma_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ph2_rising,
  input  logic        ph2_falling,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rnw,
  input  logic [7:0]  cpu_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_rnw,
  output logic [7:0]  mem_wdata,
  output logic        cpu_rdy,
  output logic        dma_busy,
  output logic        dma_done
);

  localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       parity;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] data_byte;
  logic       ph2_rising_unused;

  // ph2_rising is a timing reference only; nothing here depends on it.
  assign ph2_rising_unused = ph2_rising;

  always_comb begin
    state_next = state;
    if (ph2_falling) begin
      case (state)
        IDLE:    if (cpu_addr == DMA_REG_ADDR && !cpu_rnw) state_next = HALT;
        HALT:    state_next = parity ? READ : ALIGN;
        ALIGN:   state_next = READ;
        READ:    state_next = WRITE;
        WRITE:   state_next = (idx == 8'hFF) ? IDLE : READ;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      parity    <= 1'b0;
      page      <= 8'h00;
      idx       <= 8'h00;
      data_byte <= 8'h00;
      cpu_rdy   <= 1'b1;
      dma_busy  <= 1'b0;
      dma_done  <= 1'b0;
    end else begin
      state    <= state_next;
      cpu_rdy  <= (state_next == IDLE);
      dma_busy <= (state_next != IDLE);
      dma_done <= (state == WRITE) && (state_next == IDLE);
      if (ph2_falling) parity <= ~parity;
      if (state == IDLE && state_next == HALT) begin
        page <= cpu_wdata;
        idx  <= 8'h00;
      end
      // Memory manager clears its output on this same edge; capture pre-clear value.
      if (state == READ && ph2_falling) data_byte <= mem_rdata;
      if (state == WRITE && state_next == READ) idx <= idx + 8'd1;
    end
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_rnw   = cpu_rnw;
    mem_wdata = cpu_wdata;
    case (state)
      HALT, ALIGN: mem_rnw = 1'b1;
      READ: begin
        mem_addr = {page, idx};
        mem_rnw  = 1'b1;
      end
      WRITE: begin
        mem_addr  = OAM_DATA_ADDR;
        mem_rnw   = 1'b0;
        mem_wdata = data_byte;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: memory model, M2 phase generator and a
// per-cycle bus monitor; checks stall length, OAM data stream and abort.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  phase = 2'd0;
  logic        ph2_rising, ph2_falling;
  logic [15:0] cpu_addr = 16'h0010;
  logic        cpu_rnw = 1'b1;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  mem_rdata;
  logic [15:0] mem_addr;
  logic        mem_rnw;
  logic [7:0]  mem_wdata;
  logic        cpu_rdy, dma_busy, dma_done;

  logic [7:0]  mem [0:65535];
  logic        tb_parity = 1'b0;

  int          stall_cnt = 0, done_cnt = 0, other_cnt = 0, pt_err = 0;
  logic [7:0]  oam_q[$];
  logic [15:0] rd_q[$];
  logic        rd_par_q[$];

  int          passes = 0, total = 0;

  oam_dma_ctrl dut (
    .clk(clk), .rst(rst), .ph2_rising(ph2_rising), .ph2_falling(ph2_falling),
    .cpu_addr(cpu_addr), .cpu_rnw(cpu_rnw), .cpu_wdata(cpu_wdata),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_rnw(mem_rnw),
    .mem_wdata(mem_wdata), .cpu_rdy(cpu_rdy), .dma_busy(dma_busy),
    .dma_done(dma_done)
  );

  always #5 clk = ~clk;

  // Four clks per M2 cycle: rising pulse in phase 0, falling pulse in phase 3.
  always @(negedge clk) phase <= phase + 2'd1;
  assign ph2_rising  = (phase == 2'd0);
  assign ph2_falling = (phase == 2'd3);
  assign mem_rdata   = mem[mem_addr];

  always @(posedge clk) begin
    if (rst) tb_parity <= 1'b0;
    else if (ph2_falling) tb_parity <= ~tb_parity;
  end

  // Mid-cycle bus monitor (old phase 1 = bus stable inside the M2 cycle).
  always @(negedge clk) begin
    if (dma_done) done_cnt++;
    if (phase == 2'd1 && !rst) begin
      if (!cpu_rdy) stall_cnt++;
      if (!dma_busy) begin
        if (mem_addr !== cpu_addr || mem_rnw !== cpu_rnw ||
            mem_wdata !== cpu_wdata || cpu_rdy !== 1'b1) pt_err++;
      end else if (!mem_rnw && mem_addr == 16'h2004) begin
        oam_q.push_back(mem_wdata);
      end else if (mem_rnw && mem_addr == cpu_addr) begin
        other_cnt++;
      end else if (mem_rnw) begin
        rd_q.push_back(mem_addr);
        rd_par_q.push_back(tb_parity);
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic sync_cycle();
    do @(negedge clk); while (phase != 2'd3);
  endtask

  task automatic cpu_cyc(input logic [15:0] a, input logic rnw, input logic [7:0] d);
    cpu_addr = a; cpu_rnw = rnw; cpu_wdata = d;
    sync_cycle();
  endtask

  task automatic trigger(input logic [7:0] pg, input logic want_par);
    if (tb_parity != want_par) cpu_cyc(16'h0010, 1'b1, 8'h00);
    cpu_cyc(16'h4014, 1'b0, pg);
    cpu_addr = 16'h0010; cpu_rnw = 1'b1; cpu_wdata = 8'h00;
  endtask

  task automatic wait_done(input string tag, input int dbase);
    int n;
    n = 0;
    while (done_cnt == dbase && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_no_timeout"}, int'(done_cnt != dbase), 1);
    if (phase != 2'd0) sync_cycle();
    repeat (2) cpu_cyc(16'h0010, 1'b1, 8'h00);
  endtask

  // kind 0: page $02 (value=index); kind 1: page $80 ROM image.
  task automatic check_data(input string tag, input int ob, input int kind);
    int bad;
    logic [7:0] e;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      e = (kind == 0) ? 8'(i) : 8'(i * 7 + 3);
      if (ob + i >= oam_q.size() || oam_q[ob + i] !== e) bad++;
    end
    chk({tag, "_data"}, bad, 0);
  endtask

  int sb, db, ob, rb, xb;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = 8'(i);
      mem[16'h0300 + i] = 8'(~i);
      mem[16'h8000 + i] = 8'(i * 7 + 3);
    end

    repeat (6) @(negedge clk);
    sync_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cpu_rdy", int'(cpu_rdy), 1);
    chk("rst_dma_busy", int'(dma_busy), 0);
    chk("rst_dma_done", int'(dma_done), 0);
    chk("rst_passthru_addr", int'(mem_addr), int'(cpu_addr));
    sync_cycle();

    for (int i = 0; i < 40; i++) begin
      logic [15:0] a;
      a = 16'($urandom_range(0, 65535));
      if (a == 16'h4014) a = 16'h4015;
      cpu_cyc(a, 1'($urandom), 8'($urandom));
    end
    cpu_addr = 16'h0010; cpu_rnw = 1'b1;
    chk("idle_passthru_err", pt_err, 0);
    chk("idle_no_done", done_cnt, 0);

    // Even-parity trigger
    sb = stall_cnt; db = done_cnt; ob = oam_q.size(); rb = rd_q.size(); xb = other_cnt;
    trigger(8'h02, 1'b0);
    wait_done("even", db);
    chk("even_stall", stall_cnt - sb, 513);
    chk("even_done_pulses", done_cnt - db, 1);
    chk("even_oam_count", oam_q.size() - ob, 256);
    check_data("even", ob, 0);
    chk("even_dummy_cycles", other_cnt - xb, 1);
    chk("even_first_rd_addr", int'(rd_q[rb]), 16'h0200);

    // Odd-parity trigger
    sb = stall_cnt; db = done_cnt; ob = oam_q.size(); rb = rd_q.size(); xb = other_cnt;
    trigger(8'h02, 1'b1);
    wait_done("odd", db);
    chk("odd_stall", stall_cnt - sb, 514);
    chk("odd_dummy_cycles", other_cnt - xb, 2);
    chk("odd_first_rd_addr", int'(rd_q[rb]), 16'h0200);
    chk("odd_first_rd_parity", int'(rd_par_q[rb]), 0);
    check_data("odd", ob, 0);

    // PRG ROM source page
    sb = stall_cnt; db = done_cnt; ob = oam_q.size(); rb = rd_q.size();
    trigger(8'h80, 1'b0);
    wait_done("prg", db);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++)
        if (rb + i >= rd_q.size() || rd_q[rb + i] !== 16'(16'h8000 + i) || rd_par_q[rb + i] !== 1'b0) bad++;
      chk("prg_read_seq", bad, 0);
    end
    chk("prg_read_count", rd_q.size() - rb, 256);
    check_data("prg", ob, 1);
    chk("prg_stall", stall_cnt - sb, 513);

    // Retrigger to page $03 while busy must be ignored
    db = done_cnt; ob = oam_q.size();
    trigger(8'h02, 1'b0);
    repeat (20) cpu_cyc(16'h0010, 1'b1, 8'h00);
    repeat (3) cpu_cyc(16'h4014, 1'b0, 8'h03);
    cpu_addr = 16'h0010; cpu_rnw = 1'b1;
    wait_done("retrig", db);
    chk("retrig_oam_count", oam_q.size() - ob, 256);
    check_data("retrig", ob, 0);
    chk("retrig_done_pulses", done_cnt - db, 1);

    // Reset at idx=$40
    db = done_cnt; ob = oam_q.size(); rb = rd_q.size();
    trigger(8'h02, 1'b0);
    begin
      int n;
      n = 0;
      while (rd_q.size() - rb < 'h41 && n < 400) begin
        sync_cycle();
        n++;
      end
      chk("abort_reached_idx40", rd_q.size() - rb, 'h41);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_dma_busy", int'(dma_busy), 0);
    chk("abort_cpu_rdy", int'(cpu_rdy), 1);
    chk("abort_passthru_rnw", int'(mem_rnw), int'(cpu_rnw));
    rst = 1'b0;
    sync_cycle();
    repeat (20) cpu_cyc(16'h0010, 1'b1, 8'h00);
    chk("abort_oam_count", oam_q.size() - ob, 'h40);
    chk("abort_no_done", done_cnt - db, 0);

    sb = stall_cnt; db = done_cnt; ob = oam_q.size();
    trigger(8'h02, 1'b0);
    wait_done("fresh", db);
    chk("fresh_stall", stall_cnt - sb, 513);
    chk("fresh_oam_count", oam_q.size() - ob, 256);
    check_data("fresh", ob, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

Sprite DMA controller for the NES CPU bus. It sits between the 6502 core and the memory manager's CPU port. When the CPU writes a page number to $4014, the block stalls the CPU and takes over the bus. It then copies 256 bytes from CPU address {page, 8'h00}..{page, 8'hFF} to the PPU OAM data port ($2004) using NES-accurate get/put cycle sequencing. When idle, all CPU bus signals pass straight through to the memory manager.

## Interface
- DMA_REG_ADDR, 16'h4014, CPU address whose write starts a DMA
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high; clock: clk
- ph2_rising  in  1  one-clk pulse at the start of each M2 (CPU) cycle
- ph2_falling  in  1  one-clk pulse at the end of each M2 cycle
- cpu_addr  in  16  CPU core address
- cpu_rnw  in  1  CPU core read/not-write
- cpu_wdata  in  8  CPU core write data
- mem_rdata  in  8  read data from the memory manager; valid on the clk where ph2_falling=1
- mem_addr  out  16  address to the memory manager / register decoders (combinational mux)
- mem_rnw  out  1  read/not-write to the memory manager (combinational mux)
- mem_wdata  out  8  write data to the memory manager (combinational mux)
- cpu_rdy  out  1  registered; 0 stalls the CPU core
- dma_busy  out  1  registered; 1 whenever state is not IDLE
- dma_done  out  1  registered one-clk pulse after the last OAM write

## Operation
- parity: 1-bit M2 cycle counter that toggles on every ph2_falling. Reset value 0. Parity 0 is a "get" cycle and parity 1 is a "put" cycle.
- States are IDLE, HALT, ALIGN, READ, WRITE. All transitions happen only on the clk where ph2_falling=1.
- IDLE:
  - If cpu_addr==DMA_REG_ADDR and cpu_rnw==0, latch page<=cpu_wdata[7:0] and idx<=0, then go to HALT.
  - Otherwise stay in IDLE.
- HALT: the next state is READ if parity (before toggle) ==1, otherwise ALIGN. Equivalently, READ always starts on a get cycle.
- ALIGN: go to READ.
- READ: latch byte<=mem_rdata, then go to WRITE.
- WRITE:
  - If idx==8'hFF, go to IDLE and pulse dma_done.
  - Otherwise idx<=idx+1 (8-bit, wraps) and go to READ.
- Bus mux:
  - IDLE: mem_addr=cpu_addr, mem_rnw=cpu_rnw, mem_wdata=cpu_wdata.
  - HALT and ALIGN: mem_addr=cpu_addr, mem_rnw=1 (dummy read with the CPU stalled), mem_wdata=cpu_wdata.
  - READ: mem_addr={page, idx}, mem_rnw=1.
  - WRITE: mem_addr=OAM_DATA_ADDR, mem_rnw=0, mem_wdata=byte.
- cpu_rdy = ~dma_busy. Both are registered from the next-state value, so they change on the same clk as the state.
- A write to DMA_REG_ADDR while busy is ignored; the DMA engine itself never writes that address.
- The source page is unrestricted: pages $00-$FF are read as-is, including register space.
- Reset values: state IDLE, parity 0, page 0, idx 0, byte 0, cpu_rdy 1, dma_busy 0, dma_done 0.
- Reset mid-transfer: abort immediately. The bus returns to pass-through on the next clk, cpu_rdy=1, and no dma_done pulse is issued.

## Timing
- The $4014 write cycle completes at its ph2_falling. HALT occupies the whole next M2 cycle, and cpu_rdy=0 from the clk after that ph2_falling.
- Total stall when the trigger write lands in a parity-0 cycle: 513 M2 cycles (HALT + 256×(READ, WRITE)).
- Total stall when the trigger write lands in a parity-1 cycle: 514 M2 cycles (HALT + ALIGN + 256×(READ, WRITE)).
- READ data is sampled on the ph2_falling clk of that READ cycle. The memory manager clears its output on that same edge, so the sample uses the pre-clear value.
- The OAM write is performed by the downstream decoder at the ph2_falling of the WRITE cycle. mem_addr, mem_rnw and mem_wdata are stable for the whole WRITE cycle.
- cpu_rdy returns to 1 and dma_done pulses on the clk after the final WRITE's ph2_falling. The CPU resumes on the next M2 cycle.
- ph2_rising is used only as a bench/assertion reference; the block has no functional dependence on it.

## Test plan
- Idle pass-through: random CPU reads and writes to $0000-$FFFF except $4014 -> mem_* equals cpu_* every clk, and cpu_rdy stays 1.
- Even-parity trigger: fill RAM $0200-$02FF with value=index, then write $02 to $4014 in a parity-0 cycle -> 513 cycles with cpu_rdy=0. The $2004 writes carry data 00,01,…,FF in order, and dma_done pulses once.
- Odd-parity trigger: same fill, write $02 in a parity-1 cycle -> 514 stall cycles. There is one ALIGN dummy read, and the first READ address $0200 occurs on a parity-0 cycle.
- PRG source page: write $80 to $4014 -> 256 reads from $8000-$80FF, and the $2004 data matches the ROM image bytes.
- Retrigger while busy: write $03 to $4014 during transfer (injected as a CPU-side write) -> page stays $02, the transfer is unchanged, and there are exactly 256 OAM writes.
- Reset mid-transfer: assert rst at idx=$40 -> next clk shows state IDLE, cpu_rdy=1, dma_busy=0, no dma_done, and no further $2004 writes. A subsequent $4014 write starts a fresh 513/514-cycle transfer.
